innings_sequencer: RTL and testbench

- Match controller for the FPGA cricket game. It sequences two innings, turns each debounced delivery press into a request to the ball-outcome generator, and keeps both teams' scores.
- It enforces the over, wicket and chase limits and raises the inning-over, game-over and winner signals.
- It sits between the button debouncer and the BCD display driver, and drives the LEDs with ball/over progress.

---
 rtl/innings_sequencer_pkg.sv | 43 ++++
 rtl/innings_sequencer_team_scoreboard.sv | 78 +++++++
 rtl/innings_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_innings_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/innings_sequencer_pkg.sv
// rtl/innings_sequencer_pkg.sv - shared encodings, widths and default limits for the match controller
package innings_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_BAT1  = 3'd0,
        ST_WAIT1 = 3'd1,
        ST_BREAK = 3'd2,
        ST_BAT2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int OUT_RUNS_W = 3;
    localparam int WKT_W      = 4;
    localparam int BALL_W     = 3;
    localparam int OVER_W     = 4;

    localparam int DEF_BALLS_PER_OVER = 6;
    localparam int DEF_MAX_OVERS      = 2;
    localparam int DEF_MAX_WICKETS    = 10;
    localparam int DEF_RUN_W          = 8;

    typedef struct packed {
        logic [OUT_RUNS_W-1:0] runs;
        logic                  wicket;
        logic                  extra;
    } outcome_t;

    // The generator can emit 7; the game has no seven off the bat.
    function automatic logic [OUT_RUNS_W-1:0] clamp_runs(input logic [OUT_RUNS_W-1:0] r);
        return (r == 3'd7) ? 3'd6 : r;
    endfunction

    function automatic logic [5:0] ball_thermometer(input logic [BALL_W-1:0] b);
        logic [5:0] t;
        t = '0;
        for (int i = 0; i < 6; i++) begin
            t[i] = (b > 3'(i));
        end
        return t;
    endfunction

endpackage

// File: rtl/innings_sequencer_team_scoreboard.sv
// rtl/innings_sequencer_team_scoreboard.sv - one team's runs, wickets, balls and overs with saturation
module team_scoreboard
    import innings_sequencer_pkg::*;
#(
    parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
    parameter int MAX_WICKETS    = DEF_MAX_WICKETS,
    parameter int RUN_W          = DEF_RUN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_apply,
    input  outcome_t          i_outcome,
    output logic [RUN_W-1:0]  o_runs,
    output logic [WKT_W-1:0]  o_wkts,
    output logic [BALL_W-1:0] o_balls,
    output logic [OVER_W-1:0] o_overs
);

    localparam int              SUM_W   = RUN_W + 4;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [RUN_W-1:0]  r_runs;
    logic [WKT_W-1:0]  r_wkts;
    logic [BALL_W-1:0] r_balls;
    logic [OVER_W-1:0] r_overs;

    logic [OUT_RUNS_W-1:0] w_bat_runs;
    logic [3:0]            w_add;
    logic [SUM_W-1:0]      w_sum;
    logic [RUN_W-1:0]      w_runs_next;
    logic                  w_last_ball;

    // A wicket with no extra scores nothing; an extra carries its one-run penalty.
    always_comb begin
        w_bat_runs = clamp_runs(i_outcome.runs);
        w_add      = 4'd0;
        if (i_outcome.extra) begin
            w_add = 4'd1 + {1'b0, w_bat_runs};
        end else if (!i_outcome.wicket) begin
            w_add = {1'b0, w_bat_runs};
        end
    end

    assign w_sum       = SUM_W'(r_runs) + SUM_W'(w_add);
    assign w_runs_next = (w_sum > SUM_W'(RUN_MAX)) ? RUN_MAX : w_sum[RUN_W-1:0];
    assign w_last_ball = (r_balls == BALL_W'(BALLS_PER_OVER - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_runs  <= '0;
            r_wkts  <= '0;
            r_balls <= '0;
            r_overs <= '0;
        end else if (i_apply) begin
            r_runs <= w_runs_next;
            if (!i_outcome.extra) begin
                if (i_outcome.wicket && (r_wkts != WKT_W'(MAX_WICKETS))) begin
                    r_wkts <= r_wkts + 4'd1;
                end
                if (w_last_ball) begin
                    r_balls <= '0;
                    if (r_overs != '1) begin
                        r_overs <= r_overs + 4'd1;
                    end
                end else begin
                    r_balls <= r_balls + 3'd1;
                end
            end
        end
    end

    assign o_runs  = r_runs;
    assign o_wkts  = r_wkts;
    assign o_balls = r_balls;
    assign o_overs = r_overs;

endmodule

// File: rtl/innings_sequencer.sv
// rtl/innings_sequencer.sv - two-innings match sequencer, outcome request handshake and result logic
module innings_sequencer
    import innings_sequencer_pkg::*;
#(
    parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
    parameter int MAX_OVERS      = DEF_MAX_OVERS,
    parameter int MAX_WICKETS    = DEF_MAX_WICKETS,
    parameter int RUN_W          = DEF_RUN_W
) (
    input  logic                  clk_fpga,
    input  logic                  reset,
    input  logic                  delivery,
    input  logic                  sw,
    output logic                  out_req,
    input  logic                  out_valid,
    input  logic [OUT_RUNS_W-1:0] out_runs,
    input  logic                  out_wicket,
    input  logic                  out_extra,
    output logic [RUN_W-1:0]      disp_runs,
    output logic [WKT_W-1:0]      disp_wkts,
    output logic                  batting,
    output logic [BALL_W-1:0]     ball_in_over,
    output logic [OVER_W-1:0]     over_cnt,
    output logic                  inning_over,
    output logic                  game_over,
    output logic                  winner,
    output logic                  tie,
    output logic [7:0]            led
);

    state_t r_state;
    logic   r_eval;
    logic   r_out_req;
    logic   r_batting;
    logic   r_waiting;
    logic   r_inning_over;
    logic   r_game_over;
    logic   r_winner;
    logic   r_tie;

    outcome_t          w_outcome;
    logic              w_in_wait;
    logic              w_accept;
    logic              w_apply1;
    logic              w_apply2;
    logic              w_clear2;
    logic              w_end1;
    logic              w_end2;
    logic [RUN_W-1:0]  w_runs1;
    logic [RUN_W-1:0]  w_runs2;
    logic [WKT_W-1:0]  w_wkts1;
    logic [WKT_W-1:0]  w_wkts2;
    logic [BALL_W-1:0] w_balls1;
    logic [BALL_W-1:0] w_balls2;
    logic [OVER_W-1:0] w_overs1;
    logic [OVER_W-1:0] w_overs2;

    assign w_outcome = '{runs: out_runs, wicket: out_wicket, extra: out_extra};

    // r_eval marks the cycle after an accepted outcome: totals are settled, so
    // the innings-end test runs on registered values and further strobes are ignored.
    assign w_in_wait = (r_state == ST_WAIT1) || (r_state == ST_WAIT2);
    assign w_accept  = w_in_wait && !r_eval && out_valid;
    assign w_apply1  = w_accept && (r_state == ST_WAIT1);
    assign w_apply2  = w_accept && (r_state == ST_WAIT2);
    assign w_clear2  = (r_state == ST_BREAK) && delivery;

    team_scoreboard #(
        .BALLS_PER_OVER (BALLS_PER_OVER),
        .MAX_WICKETS    (MAX_WICKETS),
        .RUN_W          (RUN_W)
    ) u_team1 (
        .clk       (clk_fpga),
        .reset     (reset),
        .i_clear   (1'b0),
        .i_apply   (w_apply1),
        .i_outcome (w_outcome),
        .o_runs    (w_runs1),
        .o_wkts    (w_wkts1),
        .o_balls   (w_balls1),
        .o_overs   (w_overs1)
    );

    team_scoreboard #(
        .BALLS_PER_OVER (BALLS_PER_OVER),
        .MAX_WICKETS    (MAX_WICKETS),
        .RUN_W          (RUN_W)
    ) u_team2 (
        .clk       (clk_fpga),
        .reset     (reset),
        .i_clear   (w_clear2),
        .i_apply   (w_apply2),
        .i_outcome (w_outcome),
        .o_runs    (w_runs2),
        .o_wkts    (w_wkts2),
        .o_balls   (w_balls2),
        .o_overs   (w_overs2)
    );

    assign w_end1 = (w_wkts1 == WKT_W'(MAX_WICKETS)) || (w_overs1 == OVER_W'(MAX_OVERS));
    assign w_end2 = (w_wkts2 == WKT_W'(MAX_WICKETS)) || (w_overs2 == OVER_W'(MAX_OVERS))
                 || (w_runs2 > w_runs1);

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            r_state       <= ST_BAT1;
            r_eval        <= 1'b0;
            r_out_req     <= 1'b0;
            r_batting     <= 1'b0;
            r_waiting     <= 1'b0;
            r_inning_over <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
            r_tie         <= 1'b0;
        end else begin
            r_out_req <= 1'b0;
            case (r_state)
                ST_BAT1: begin
                    if (delivery) begin
                        r_state   <= ST_WAIT1;
                        r_out_req <= 1'b1;
                        r_waiting <= 1'b1;
                    end
                end
                ST_WAIT1: begin
                    if (r_eval) begin
                        r_eval    <= 1'b0;
                        r_waiting <= 1'b0;
                        if (w_end1) begin
                            r_state       <= ST_BREAK;
                            r_inning_over <= 1'b1;
                        end else begin
                            r_state <= ST_BAT1;
                        end
                    end else if (out_valid) begin
                        r_eval <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (delivery) begin
                        r_state       <= ST_BAT2;
                        r_batting     <= 1'b1;
                        r_inning_over <= 1'b0;
                    end
                end
                ST_BAT2: begin
                    if (delivery) begin
                        r_state   <= ST_WAIT2;
                        r_out_req <= 1'b1;
                        r_waiting <= 1'b1;
                    end
                end
                ST_WAIT2: begin
                    if (r_eval) begin
                        r_eval    <= 1'b0;
                        r_waiting <= 1'b0;
                        if (w_end2) begin
                            r_state       <= ST_DONE;
                            r_inning_over <= 1'b1;
                            r_game_over   <= 1'b1;
                            r_winner      <= (w_runs2 > w_runs1);
                            r_tie         <= (w_runs2 == w_runs1);
                        end else begin
                            r_state <= ST_BAT2;
                        end
                    end else if (out_valid) begin
                        r_eval <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_BAT1;
                end
            endcase
        end
    end

    assign out_req      = r_out_req;
    assign batting      = r_batting;
    assign inning_over  = r_inning_over;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign tie          = r_tie;
    assign ball_in_over = r_batting ? w_balls2 : w_balls1;
    assign over_cnt     = r_batting ? w_overs2 : w_overs1;
    assign disp_runs    = sw ? w_runs2 : w_runs1;
    assign disp_wkts    = sw ? w_wkts2 : w_wkts1;
    assign led          = {r_batting, r_waiting, ball_thermometer(ball_in_over)};

endmodule

// File: tb/tb_innings_sequencer.sv
// tb/tb_innings_sequencer.sv - scoreboard bench: stimulus queues expectations, monitors pop and compare
module tb_innings_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, delivery = 1'b0, sw = 1'b0, out_valid = 1'b0;
    logic [2:0] out_runs = 3'd0;
    logic       out_wicket = 1'b0, out_extra = 1'b0;
    logic       out_req, batting, inning_over, game_over, winner, tie;
    logic [7:0] disp_runs, led;
    logic [3:0] disp_wkts, over_cnt;
    logic [2:0] ball_in_over;

    logic       s_reset = 1'b1, s_delivery = 1'b0, s_valid = 1'b0;
    logic [2:0] s_runs = 3'd0;
    logic       s_req, s_batting, s_inning_over, s_game_over, s_winner, s_tie;
    logic [3:0] s_disp_runs, s_disp_wkts, s_over_cnt;
    logic [2:0] s_ball;
    logic [7:0] s_led;

    innings_sequencer dut (
        .clk_fpga(clk), .reset(reset), .delivery(delivery), .sw(sw),
        .out_req(out_req), .out_valid(out_valid), .out_runs(out_runs),
        .out_wicket(out_wicket), .out_extra(out_extra),
        .disp_runs(disp_runs), .disp_wkts(disp_wkts), .batting(batting),
        .ball_in_over(ball_in_over), .over_cnt(over_cnt), .inning_over(inning_over),
        .game_over(game_over), .winner(winner), .tie(tie), .led(led)
    );

    innings_sequencer #(.RUN_W(4)) u_sat (
        .clk_fpga(clk), .reset(s_reset), .delivery(s_delivery), .sw(1'b0),
        .out_req(s_req), .out_valid(s_valid), .out_runs(s_runs),
        .out_wicket(1'b0), .out_extra(1'b0),
        .disp_runs(s_disp_runs), .disp_wkts(s_disp_wkts), .batting(s_batting),
        .ball_in_over(s_ball), .over_cnt(s_over_cnt), .inning_over(s_inning_over),
        .game_over(s_game_over), .winner(s_winner), .tie(s_tie), .led(s_led)
    );

    typedef struct {
        int runs, wkts, balls, overs;
        logic bat, io, go, win, tie;
    } snap_t;

    snap_t snap_q[$];
    logic  req_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic snap_t mk(input int r, input int w, input int b, input int o,
                                 input logic bat, input logic io, input logic go,
                                 input logic win, input logic t);
        snap_t s;
        s.runs = r; s.wkts = w; s.balls = b; s.overs = o;
        s.bat = bat; s.io = io; s.go = go; s.win = win; s.tie = t;
        return s;
    endfunction

    function automatic int led_exp(input logic bat, input int balls);
        logic [7:0] v;
        v = '0;
        v[7] = bat;
        for (int i = 0; i < 6; i++) v[i] = (balls > i);
        return int'(v);
    endfunction

    // out_req monitor: every pulse must match a delivery the stimulus expected to be accepted
    initial begin
        logic b;
        forever begin
            @(negedge clk);
            if (out_req === 1'b1) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_out_req", 1, 0);
                end else begin
                    b = req_q.pop_front();
                    chk("req_batting", int'(batting), int'(b));
                    chk("req_led_waiting", int'(led[6]), 1);
                end
            end
        end
    end

    // outcome monitor: one cycle after each strobe the settled status must match
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            if (out_valid === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                if (snap_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = snap_q.pop_front();
                    chk("disp_runs", int'(disp_runs), e.runs);
                    chk("disp_wkts", int'(disp_wkts), e.wkts);
                    chk("ball_in_over", int'(ball_in_over), e.balls);
                    chk("over_cnt", int'(over_cnt), e.overs);
                    chk("batting", int'(batting), int'(e.bat));
                    chk("inning_over", int'(inning_over), int'(e.io));
                    chk("game_over", int'(game_over), int'(e.go));
                    chk("winner", int'(winner), int'(e.win));
                    chk("tie", int'(tie), int'(e.tie));
                    chk("led", int'(led), led_exp(e.bat, e.balls));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; delivery = 1'b0; out_valid = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic exp_req, input logic exp_bat);
        @(negedge clk);
        delivery = 1'b1;
        if (exp_req) req_q.push_back(exp_bat);
        @(negedge clk);
        delivery = 1'b0;
    endtask

    task automatic answer(input int r, input logic w, input logic x, input snap_t e);
        @(negedge clk);
        out_valid = 1'b1; out_runs = 3'(r); out_wicket = w; out_extra = x;
        snap_q.push_back(e);
        @(negedge clk);
        out_valid = 1'b0; out_wicket = 1'b0; out_extra = 1'b0;
        cyc(2);
    endtask

    task automatic ball(input int r, input logic w, input logic x, input logic bat, input snap_t e);
        press(1'b1, bat);
        cyc(1);
        answer(r, w, x, e);
    endtask

    task automatic chk_bat2_start();
        chk("b2_batting", int'(batting), 1);
        chk("b2_ball_in_over", int'(ball_in_over), 0);
        chk("b2_over_cnt", int'(over_cnt), 0);
        chk("b2_inning_over", int'(inning_over), 0);
        chk("b2_led", int'(led), 8'h80);
    endtask

    initial begin
        int k, r;
        int sat_exp[4] = '{6, 12, 15, 15};

        // Game A: reset state, six singles, double press, extras, over limit, chase win
        do_reset();
        sw = 1'b0;
        #1;
        chk("rst_out_req", int'(out_req), 0);
        chk("rst_disp_runs", int'(disp_runs), 0);
        chk("rst_disp_wkts", int'(disp_wkts), 0);
        chk("rst_batting", int'(batting), 0);
        chk("rst_ball_in_over", int'(ball_in_over), 0);
        chk("rst_over_cnt", int'(over_cnt), 0);
        chk("rst_inning_over", int'(inning_over), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_tie", int'(tie), 0);
        chk("rst_led", int'(led), 0);

        for (k = 1; k <= 6; k++) ball(1, 0, 0, 1'b0, mk(k, 0, k % 6, k / 6, 0, 0, 0, 0, 0));

        press(1'b1, 1'b0);
        press(1'b0, 1'b0);
        answer(2, 0, 0, mk(8, 0, 1, 1, 0, 0, 0, 0, 0));
        ball(0, 0, 0, 1'b0, mk(8, 0, 2, 1, 0, 0, 0, 0, 0));
        ball(4, 0, 1, 1'b0, mk(13, 0, 2, 1, 0, 0, 0, 0, 0));
        ball(0, 1, 1, 1'b0, mk(14, 0, 2, 1, 0, 0, 0, 0, 0));
        ball(7, 0, 0, 1'b0, mk(20, 0, 3, 1, 0, 0, 0, 0, 0));
        ball(0, 0, 0, 1'b0, mk(20, 0, 4, 1, 0, 0, 0, 0, 0));
        ball(0, 0, 0, 1'b0, mk(20, 0, 5, 1, 0, 0, 0, 0, 0));
        ball(0, 0, 0, 1'b0, mk(20, 0, 0, 2, 0, 1, 0, 0, 0));
        answer(3, 0, 0, mk(20, 0, 0, 2, 0, 1, 0, 0, 0));

        sw = 1'b1;
        press(1'b0, 1'b1);
        #1;
        chk_bat2_start();
        chk("b2_disp_runs", int'(disp_runs), 0);

        ball(6, 0, 0, 1'b1, mk(6, 0, 1, 0, 1, 0, 0, 0, 0));
        ball(6, 0, 0, 1'b1, mk(12, 0, 2, 0, 1, 0, 0, 0, 0));
        // outcome strobe coincides with the out_req pulse
        @(negedge clk);
        delivery = 1'b1;
        req_q.push_back(1'b1);
        @(negedge clk);
        delivery = 1'b0; out_valid = 1'b1; out_runs = 3'd3;
        snap_q.push_back(mk(15, 0, 3, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        out_valid = 1'b0;
        cyc(2);
        ball(6, 0, 0, 1'b1, mk(21, 0, 4, 0, 1, 1, 1, 1, 0));
        answer(2, 0, 0, mk(21, 0, 4, 0, 1, 1, 1, 1, 0));
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        cyc(2);
        sw = 1'b0;
        #1;
        chk("done_team1_runs", int'(disp_runs), 20);
        chk("done_game_over", int'(game_over), 1);

        // Game B: ten wickets end innings 1 before the over limit
        do_reset();
        sw = 1'b0;
        for (k = 1; k <= 10; k++)
            ball(0, 1, 0, 1'b0, mk(0, k, k % 6, k / 6, 0, k == 10, 0, 0, 0));
        press(1'b0, 1'b0);
        #1;
        chk_bat2_start();
        chk("b_team1_wkts", int'(disp_wkts), 10);
        sw = 1'b1;
        #1;
        chk("b_team2_wkts", int'(disp_wkts), 0);

        // Game C: both innings 12 balls, 7 runs each -> tie
        do_reset();
        sw = 1'b0;
        for (k = 1; k <= 12; k++) begin
            r = (k <= 7) ? 1 : 0;
            ball(r, 0, 0, 1'b0, mk((k < 7) ? k : 7, 0, k % 6, k / 6, 0, k == 12, 0, 0, 0));
        end
        sw = 1'b1;
        press(1'b0, 1'b1);
        for (k = 1; k <= 12; k++) begin
            r = (k <= 7) ? 1 : 0;
            ball(r, 0, 0, 1'b1, mk((k < 7) ? k : 7, 0, k % 6, k / 6, 1, k == 12, k == 12, 0, k == 12));
        end
        sw = 1'b0;
        #1;
        chk("tie_team1_runs", int'(disp_runs), 7);

        // Game D: reset while waiting in innings 2, then a stale strobe
        do_reset();
        sw = 1'b0;
        for (k = 1; k <= 12; k++)
            ball(0, 0, 0, 1'b0, mk(0, 0, k % 6, k / 6, 0, k == 12, 0, 0, 0));
        sw = 1'b1;
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        cyc(2);
        do_reset();
        answer(6, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        sw = 1'b0;
        #1;
        chk("d_team1_runs", int'(disp_runs), 0);
        chk("d_led", int'(led), 0);

        // Saturation on a 4-bit run total
        @(negedge clk);
        s_reset = 1'b1;
        cyc(2);
        s_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) s_delivery = 1'b1;
            @(negedge clk) s_delivery = 1'b0;
            cyc(1);
            @(negedge clk) begin s_valid = 1'b1; s_runs = 3'd6; end
            @(negedge clk) s_valid = 1'b0;
            cyc(2);
            chk("sat_runs", int'(s_disp_runs), sat_exp[i]);
        end

        for (int i = 0; i < 20 && (snap_q.size() != 0 || req_q.size() != 0); i++) @(negedge clk);
        chk("snap_q_drained", snap_q.size(), 0);
        chk("req_q_drained", req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
